// File: rtl/approx_adder_err_monitor_if.sv
// Sample stream into the error monitor: operands plus the
// approximate sum, with a valid/ready handshake.
interface approx_adder_err_monitor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   in_sum;

  modport master (
    output in_valid, in_a, in_b, in_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum,
    output in_ready
  );
endinterface

// File: rtl/approx_adder_err_monitor.sv
// Windowed error statistics for an approximate adder under test.
// Optional MON_BIAS_EN adds signed error sum and mean error outputs.
module approx_adder_err_monitor #(
  parameter int WIDTH        = 16,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  approx_adder_err_monitor_if.slave       s,
  output logic                            busy,
  output logic                            done,
  output logic [LOG2_SAMPLES:0]           err_count,
  output logic [WIDTH:0]                  max_ed,
  output logic [2*(WIDTH+1)+LOG2_SAMPLES-1:0] sse,
`ifdef MON_BIAS_EN
  output logic [2*(WIDTH+1)-1:0]          mse,
  output logic signed [WIDTH+1+LOG2_SAMPLES:0] err_sum,
  output logic signed [WIDTH+1:0]         mean_err
`else
  output logic [2*(WIDTH+1)-1:0]          mse
`endif
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = LOG2_SAMPLES + 1;
  localparam int SW = 2 * W1 + LOG2_SAMPLES;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic          s1_valid;
  logic [W1-1:0] s1_ed;
  logic          s1_nz;

  logic          accept;
  logic [W1-1:0] exact;
  logic [W1-1:0] ed_c;
  logic [2*W1-1:0] ed_w;
  logic [2*W1-1:0] sq;

  assign accept = s.in_valid & s.in_ready;
  assign exact  = W1'(s.in_a) + W1'(s.in_b);
  assign ed_c   = (exact >= s.in_sum) ? exact - s.in_sum
                                      : s.in_sum - exact;
  assign ed_w   = {{W1{1'b0}}, s1_ed};
  // 2*W1 bits hold the full square, so nothing is lost here
  assign sq     = ed_w * ed_w;

`ifdef MON_BIAS_EN
  logic signed [W1:0] diff_c;
  logic signed [W1:0] s1_diff;
  assign diff_c = $signed({1'b0, exact}) - $signed({1'b0, s.in_sum});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      s1_valid   <= 1'b0;
      s1_ed      <= '0;
      s1_nz      <= 1'b0;
      s.in_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      max_ed     <= '0;
      sse        <= '0;
      mse        <= '0;
`ifdef MON_BIAS_EN
      s1_diff    <= '0;
      err_sum    <= '0;
      mean_err   <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ed <= ed_c;
        s1_nz <= (ed_c != '0);
`ifdef MON_BIAS_EN
        s1_diff <= diff_c;
`endif
      end

      if (s1_valid) begin
        sse       <= sse + {{LOG2_SAMPLES{1'b0}}, sq};
        err_count <= err_count + {{LOG2_SAMPLES{1'b0}}, s1_nz};
        if (s1_ed > max_ed) max_ed <= s1_ed;
`ifdef MON_BIAS_EN
        err_sum <= err_sum
                 + {{LOG2_SAMPLES{s1_diff[W1]}}, s1_diff};
`endif
      end

      mse <= sse[SW-1:LOG2_SAMPLES];
`ifdef MON_BIAS_EN
      mean_err <= err_sum[WIDTH+1+LOG2_SAMPLES:LOG2_SAMPLES];
`endif

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            sample_cnt <= '0;
            s.in_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            max_ed     <= '0;
            sse        <= '0;
            mse        <= '0;
`ifdef MON_BIAS_EN
            err_sum    <= '0;
            mean_err   <= '0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST) begin
              state      <= DRAIN;
              s.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // accumulators take the last stage-1 sample this cycle
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed checks of the approximate adder error monitor.
// Covers exact, constant, worst-case, gaps, start and reset.
module tb_approx_adder_err_monitor;
  localparam int W = 16;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [L:0] err_count;
  logic [W:0] max_ed;
  logic [2*(W+1)+L-1:0] sse;
  logic [2*(W+1)-1:0] mse;
`ifdef MON_BIAS_EN
  logic signed [W+1+L:0] err_sum;
  logic signed [W+1:0] mean_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ac;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  approx_adder_err_monitor_if #(.WIDTH(W)) bus();

  approx_adder_err_monitor #(.WIDTH(W), .LOG2_SAMPLES(L)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s(bus.slave),
    .busy(busy),
    .done(done),
    .err_count(err_count),
    .max_ed(max_ed),
    .sse(sse),
`ifdef MON_BIAS_EN
    .mse(mse),
    .err_sum(err_sum),
    .mean_err(mean_err)
`else
    .mse(mse)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic results(input string tag, input int ec,
                         input logic [63:0] med, input logic [63:0] s2,
                         input logic [63:0] ms);
    chk({tag, "_err_count"}, 64'(err_count), 64'(ec));
    chk({tag, "_max_ed"}, 64'(max_ed), med);
    chk({tag, "_sse"}, 64'(sse), s2);
    chk({tag, "_mse"}, 64'(mse), ms);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_data(input int kind, input int idx);
    logic [W-1:0] a, b;
    a = W'($urandom_range(65535));
    b = W'($urandom_range(65535));
    if (kind == 1) begin
      bus.in_a = 16'd3; bus.in_b = 16'd5; bus.in_sum = 17'd3;
    end else if (kind == 2 && idx == 0) begin
      bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_sum = 17'd0;
    end else begin
      bus.in_a = a; bus.in_b = b;
      bus.in_sum = 17'(a) + 17'(b);
    end
  endtask

  task automatic stream(input int kind, input int n, input int gap,
                        input int start_at, output int acc_cyc);
    int acc = 0;
    int guard = 0;
    bit sp = 1'b0;
    acc_cyc = -100;
    while (acc < n && guard < 5000) begin
      bus.in_valid = (gap == 0) ? 1'b1
                   : ($urandom_range(99) >= 32'(gap));
      set_data(kind, acc);
      start = (acc == start_at) && !sp;
      if (start) sp = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        if (acc == n) acc_cyc = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("accepted", 64'(acc), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int acc_cyc);
    int g = 0;
    while (!done && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd3);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sum = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    results("rst", 0, 0, 0, 0);

    // exact stream
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    stream(0, 256, 0, -1, ac);
    chk("exact_ready_low", 64'(bus.in_ready), 64'd0);
    wait_done("exact", ac);
    results("exact", 0, 0, 0, 0);
    chk("exact_busy_low", 64'(busy), 64'd0);

    // constant error
    pulse_start();
    chk("restart_done_low", 64'(done), 64'd0);
    stream(1, 256, 0, -1, ac);
    wait_done("const", ac);
    results("const", 256, 5, 6400, 25);
`ifdef MON_BIAS_EN
    chk("const_err_sum", 64'(err_sum), 64'd1280);
    chk("const_mean_err", 64'(mean_err), 64'd5);
`endif

    // worst-case single error
    pulse_start();
    stream(2, 256, 0, -1, ac);
    wait_done("worst", ac);
    results("worst", 1, 131070, 64'd17179344900, 64'd67106816);

    // gaps plus extra offered samples after the window
    pulse_start();
    stream(1, 256, 50, -1, ac);
    chk("gap_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    set_data(1, 0);
    wait_done("gap", ac);
    results("gap", 256, 5, 6400, 25);
    repeat (5) @(posedge clk);
    #1;
    chk("extra_err_count", 64'(err_count), 64'd256);
    chk("extra_sse", 64'(sse), 64'd6400);
    chk("extra_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;

    // start during RUN is ignored
    pulse_start();
    stream(1, 256, 0, 100, ac);
    wait_done("midstart", ac);
    results("midstart", 256, 5, 6400, 25);

    // reset mid-window
    pulse_start();
    stream(1, 128, 0, -1, ac);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(bus.in_ready), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    results("mrst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_idle", 64'(busy), 64'd0);
    pulse_start();
    stream(1, 256, 0, -1, ac);
    wait_done("after_rst", ac);
    results("after_rst", 256, 5, 6400, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
